// File: rtl/bayer_mosaic_gen.sv
// bayer_mosaic_gen: re-mosaics an RGB pixel stream into a single-channel Bayer stream
// through a one-stage registered output. Define MOSAIC_LEN_CHECK_EN for line-length checking.
module bayer_mosaic_gen #(
    parameter int DATA_W = 10,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        cfg_pattern,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_r,
    input  logic [DATA_W-1:0] s_g,
    input  logic [DATA_W-1:0] s_b,
    input  logic              s_sof,
    input  logic              s_eol,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_sof,
    output logic              m_eol,
    output logic              m_eof,
    output logic              err_len
);
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    localparam logic IDLE   = 1'b0;
    localparam logic ACTIVE = 1'b1;

    logic              state_q;
    logic [COL_W-1:0]  col_q, col_eff, col_nxt;
    logic [ROW_W-1:0]  row_q, row_eff, row_nxt;
    logic [1:0]        pat_q, pat_eff;
    logic              accept, emit, line_end, frame_end, len_err, ry, cx;
    logic [DATA_W-1:0] sample;

    assign s_ready = (state_q == IDLE) || !m_valid || m_ready;
    assign accept  = s_valid && s_ready;
    assign emit    = accept && (s_sof || (state_q == ACTIVE));

    always_comb begin
        // An SOF beat is mapped as position (0,0) with the freshly sampled pattern.
        col_eff = s_sof ? '0 : col_q;
        row_eff = s_sof ? '0 : row_q;
        pat_eff = s_sof ? cfg_pattern : pat_q;
`ifdef MOSAIC_LEN_CHECK_EN
        line_end = s_eol || (col_eff == COL_LAST);
        len_err  = (s_eol != (col_eff == COL_LAST)) || (s_sof && (state_q == ACTIVE));
`else
        line_end = s_eol;
        len_err  = 1'b0;
`endif
        frame_end = line_end && (row_eff == ROW_LAST);
        ry = row_eff[0] ^ pat_eff[1];
        cx = col_eff[0] ^ pat_eff[0];
        if (!ry && !cx) begin
            sample = s_r;
        end else if (ry && cx) begin
            sample = s_b;
        end else begin
            sample = s_g;
        end
        if (line_end) begin
            col_nxt = '0;
            row_nxt = frame_end ? '0 : row_eff + ROW_W'(1);
        end else begin
            col_nxt = (col_eff == COL_LAST) ? col_eff : col_eff + COL_W'(1);
            row_nxt = row_eff;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            pat_q   <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_sof   <= 1'b0;
            m_eol   <= 1'b0;
            m_eof   <= 1'b0;
            err_len <= 1'b0;
        end else begin
            err_len <= emit && len_err;
            if (emit) begin
                state_q <= frame_end ? IDLE : ACTIVE;
                col_q   <= col_nxt;
                row_q   <= row_nxt;
                pat_q   <= pat_eff;
                m_valid <= 1'b1;
                m_data  <= sample;
                m_sof   <= s_sof;
                m_eol   <= line_end;
                m_eof   <= frame_end;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_bayer_mosaic_gen.sv
// Scoreboard bench for bayer_mosaic_gen with a 4x2 image; the length-check tests
// are built only when MOSAIC_LEN_CHECK_EN is defined.
module tb_bayer_mosaic_gen;
    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    cfg_pattern = 2'd0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_r = '0, s_g = '0, s_b = '0;
    logic          s_sof = 1'b0, s_eol = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [DW-1:0] m_data;
    logic          m_sof, m_eol, m_eof, err_len;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          sof;
        logic          eol;
        logic          eof;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          got, want;
    int unsigned   n_cmp = 0;
    int unsigned   n_bad = 0;
    int unsigned   rdy_mode = 0;
    logic [DW-1:0] exp_rggb[8] = '{10'h100, 10'h201, 10'h102, 10'h203, 10'h204, 10'h305, 10'h206, 10'h307};
    logic [DW-1:0] exp_bggr[8] = '{10'h300, 10'h201, 10'h302, 10'h203, 10'h204, 10'h105, 10'h206, 10'h107};

    bayer_mosaic_gen #(.DATA_W(DW), .IMG_W(4), .IMG_H(2)) dut (
        .clk(clk), .rst(rst), .cfg_pattern(cfg_pattern),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_r(s_r), .s_g(s_g), .s_b(s_b), .s_sof(s_sof), .s_eol(s_eol),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof), .err_len(err_len)
    );

    initial forever #5 clk = ~clk;

    // Downstream ready: 0 = always ready, 1 = alternate cycles, other = stalled.
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = !m_ready;
            default: m_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_beat: got data=%h sof=%b eol=%b eof=%b, required no beat",
                         m_data, m_sof, m_eol, m_eof);
            end else begin
                want = exp_q.pop_front();
                got  = {m_data, m_sof, m_eol, m_eof};
                if (got !== want) begin
                    n_bad++;
                    $display("FAIL beat: got data=%h sof=%b eol=%b eof=%b, required data=%h sof=%b eol=%b eof=%b",
                             got.d, got.sof, got.eol, got.eof, want.d, want.sof, want.eol, want.eof);
                end
            end
        end
`ifndef MOSAIC_LEN_CHECK_EN
        n_cmp++;
        if (err_len !== 1'b0) begin
            n_bad++;
            $display("FAIL err_len_tied: got %b, required 0", err_len);
        end
`endif
    end

    function automatic exp_t mk(input logic [DW-1:0] d, input logic sof, input logic eol, input logic eof);
        exp_t e;
        e.d = d; e.sof = sof; e.eol = eol; e.eof = eof;
        return e;
    endfunction

    // Colour of pixel k at a Bayer position: pixel k carries R=0x100+k, G=0x200+k, B=0x300+k.
    function automatic logic [DW-1:0] pixval(input int k, input int pat, input int row, input int col);
        int ry, cx;
        ry = (row ^ (pat >> 1)) & 1;
        cx = (col ^ pat) & 1;
        if (ry == 0 && cx == 0) return DW'(256 + k);
        if (ry == 1 && cx == 1) return DW'(768 + k);
        return DW'(512 + k);
    endfunction

    // Called at posedge+1; holds the beat until accepted, returns at posedge+1 after the accept edge.
    task automatic send(input int k, input logic sof, input logic eol, input logic emits, input exp_t e);
        int unsigned guard = 0;
        s_valid = 1'b1;
        s_r = DW'(256 + k); s_g = DW'(512 + k); s_b = DW'(768 + k);
        s_sof = sof; s_eol = eol;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            guard++;
            if (guard > 40) begin
                n_cmp++; n_bad++;
                $display("FAIL send_timeout: beat %0d not accepted after %0d cycles, required acceptance", k, guard);
                break;
            end
            @(posedge clk); #1;
        end
        if (s_ready && emits) exp_q.push_back(e);
        @(posedge clk); #1;
        s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
    endtask

    task automatic send_frame(input logic [1:0] pat);
        for (int k = 0; k < 8; k++)
            send(k, k == 0, (k % 4) == 3, 1'b1,
                 mk(pat == 2'd0 ? exp_rggb[k] : exp_bggr[k], k == 0, (k % 4) == 3, k == 7));
    endtask

    task automatic drain();
        int unsigned guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d beats outstanding, required 0", exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp += 6;
        if (m_valid !== 1'b0) begin n_bad++; $display("FAIL reset_m_valid: got %b, required 0", m_valid); end
        if (m_data !== '0)    begin n_bad++; $display("FAIL reset_m_data: got %h, required 000", m_data); end
        if ({m_sof, m_eol, m_eof} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b, required 000", {m_sof, m_eol, m_eof}); end
        if (err_len !== 1'b0) begin n_bad++; $display("FAIL reset_err_len: got %b, required 0", err_len); end
        if (s_ready !== 1'b1) begin n_bad++; $display("FAIL reset_s_ready: got %b, required 1", s_ready); end
        if (m_eof !== 1'b0)   begin n_bad++; $display("FAIL reset_m_eof: got %b, required 0", m_eof); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_rggb();
        cfg_pattern = 2'd0;
        n_cmp++;
        if (m_valid !== 1'b0) begin n_bad++; $display("FAIL latency_pre: m_valid got %b, required 0", m_valid); end
        for (int k = 0; k < 8; k++) begin
            send(k, k == 0, (k % 4) == 3, 1'b1, mk(exp_rggb[k], k == 0, (k % 4) == 3, k == 7));
            if (k == 0) begin
                n_cmp++;
                if (m_valid !== 1'b1 || m_data !== 10'h100)
                    begin n_bad++; $display("FAIL latency: got valid=%b data=%h, required valid=1 data=100", m_valid, m_data); end
            end
        end
        drain();
    endtask

    task automatic test_bggr();
        cfg_pattern = 2'd3;
        send_frame(2'd3);
        drain();
    endtask

    task automatic test_backpressure();
        cfg_pattern = 2'd0;
        send(0, 1'b1, 1'b0, 1'b1, mk(exp_rggb[0], 1'b1, 1'b0, 1'b0));
        send(1, 1'b0, 1'b0, 1'b1, mk(exp_rggb[1], 1'b0, 1'b0, 1'b0));
        rdy_mode = 2;
        s_valid = 1'b1; s_r = DW'(258); s_g = DW'(514); s_b = DW'(770);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp += 3;
            if (s_ready !== 1'b0) begin n_bad++; $display("FAIL stall_s_ready: cycle %0d got %b, required 0", i, s_ready); end
            if (m_valid !== 1'b1) begin n_bad++; $display("FAIL stall_m_valid: cycle %0d got %b, required 1", i, m_valid); end
            if (m_data !== 10'h201) begin n_bad++; $display("FAIL stall_m_data: cycle %0d got %h, required 201", i, m_data); end
        end
        @(posedge clk); #1;
        rdy_mode = 0;
        for (int k = 2; k < 8; k++)
            send(k, 1'b0, (k % 4) == 3, 1'b1, mk(exp_rggb[k], 1'b0, (k % 4) == 3, k == 7));
        drain();
    endtask

    task automatic test_toggle();
        cfg_pattern = 2'd0;
        rdy_mode = 1;
        send_frame(2'd0);
        drain();
        rdy_mode = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_drop_restart();
        cfg_pattern = 2'd0;
        for (int k = 0; k < 3; k++) begin
            send(40 + k, 1'b0, k == 2, 1'b0, '0);
            n_cmp++;
            if (m_valid !== 1'b0) begin n_bad++; $display("FAIL drop_idle: beat %0d got m_valid=%b, required 0", k, m_valid); end
        end
        for (int k = 0; k < 6; k++)
            send(k, k == 0, k == 3, 1'b1, mk(exp_rggb[k], k == 0, k == 3, 1'b0));
        send(16, 1'b1, 1'b0, 1'b1, mk(10'h110, 1'b1, 1'b0, 1'b0));
`ifdef MOSAIC_LEN_CHECK_EN
        n_cmp++;
        if (err_len !== 1'b1) begin n_bad++; $display("FAIL restart_err_len: got %b, required 1", err_len); end
`endif
        for (int j = 1; j < 8; j++)
            send(16 + j, 1'b0, (j % 4) == 3, 1'b1, mk(pixval(16 + j, 0, j / 4, j % 4), 1'b0, (j % 4) == 3, j == 7));
        drain();
    endtask

`ifdef MOSAIC_LEN_CHECK_EN
    task automatic test_len_check();
        cfg_pattern = 2'd0;
        for (int k = 0; k < 5; k++) begin
            send(k, k == 0, 1'b0, 1'b1, mk(pixval(k, 0, k / 4, k % 4), k == 0, k == 3, 1'b0));
            if (k == 3 || k == 4) begin
                n_cmp++;
                if (err_len !== (k == 3)) begin n_bad++; $display("FAIL force_eol_err: beat %0d got %b, required %b", k, err_len, k == 3); end
            end
        end
        send(5, 1'b0, 1'b0, 1'b1, mk(10'h305, 1'b0, 1'b0, 1'b0));
        send(6, 1'b0, 1'b1, 1'b1, mk(10'h206, 1'b0, 1'b1, 1'b1));
        n_cmp++;
        if (err_len !== 1'b1) begin n_bad++; $display("FAIL short_eol_err: got %b, required 1", err_len); end
        @(posedge clk); #1;
        n_cmp++;
        if (err_len !== 1'b0) begin n_bad++; $display("FAIL short_eol_err_width: got %b, required 0", err_len); end
        drain();
    endtask
`else
    task automatic test_saturate();
        cfg_pattern = 2'd0;
        for (int k = 0; k < 6; k++)
            send(k, k == 0, k == 5, 1'b1, mk(pixval(k, 0, 0, (k < 3) ? k : 3), k == 0, k == 5, 1'b0));
        for (int k = 6; k < 10; k++)
            send(k, 1'b0, k == 9, 1'b1, mk(pixval(k, 0, 1, k - 6), 1'b0, k == 9, k == 9));
        drain();
    endtask
`endif

    task automatic test_rst_midflight();
        cfg_pattern = 2'd0;
        send(0, 1'b1, 1'b0, 1'b1, mk(exp_rggb[0], 1'b1, 1'b0, 1'b0));
        rdy_mode = 2;
        @(negedge clk);
        n_cmp++;
        if (m_valid !== 1'b1 || m_ready !== 1'b0) begin n_bad++; $display("FAIL rst_setup: got valid=%b ready=%b, required valid=1 ready=0", m_valid, m_ready); end
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp += 2;
        if (m_valid !== 1'b0) begin n_bad++; $display("FAIL rst_m_valid: got %b, required 0", m_valid); end
        if (s_ready !== 1'b1) begin n_bad++; $display("FAIL rst_s_ready: got %b, required 1", s_ready); end
        rdy_mode = 0;
        @(posedge clk); #1;
        send_frame(2'd0);
        drain();
    endtask

    initial begin
        test_reset();
        test_rggb();
        test_bggr();
        test_backpressure();
        test_toggle();
        test_drop_restart();
`ifdef MOSAIC_LEN_CHECK_EN
        test_len_check();
`else
        test_saturate();
`endif
        test_rst_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/bayer_mosaic_gen.md
# bayer_mosaic_gen

Re-mosaics a full-RGB pixel stream into a single-channel 10-bit Bayer stream: the inverse of the demosaic pipeline's green/red/blue interpolation. It sits in front of the demosaic core as a stimulus source and round-trip checker. RGB frames from memory or a test generator are converted into the CFA sample stream the 7x7 window buffer consumes. Pattern phase, row/column tracking, frame framing and output back-pressure are handled in a one-stage registered pipeline.

## Interface
Parameters:
- DATA_W, 10, bits per colour sample
- IMG_W, 640, active pixels per line (min 2)
- IMG_H, 480, active lines per frame (min 2)

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- cfg_pattern  in  2  CFA phase: 0 RGGB, 1 GRBG, 2 GBRG, 3 BGGR; sampled only on accepted SOF beat
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid && s_ready
- s_r, s_g, s_b  in  DATA_W each  input colour samples
- s_sof  in  1  first pixel of frame
- s_eol  in  1  last pixel of line
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accepts
- m_data  out  DATA_W  Bayer sample
- m_sof, m_eol, m_eof  out  1 each  framing flags aligned to m_data
- err_len  out  1  one-cycle line-length error pulse (see Configuration)

## Operation
- FSM states: IDLE, ACTIVE. Reset -> IDLE.
- IDLE: s_ready = 1. Beats without s_sof are consumed and discarded (no output). Accepted beat with s_sof: latch cfg_pattern into pat_q, col=0, row=0, emit the beat, go ACTIVE.
- ACTIVE: s_ready = !m_valid || m_ready. Each accepted beat is emitted.
- Channel select, with effective parity ry = row[0] ^ pat_q[1] and cx = col[0] ^ pat_q[0]: (ry,cx)=(0,0) -> R; (0,1) or (1,0) -> G; (1,1) -> B.
- Counters after each accepted beat: if line ends -> col=0, row=row+1; else col=col+1.
- A line ends on s_eol. Column counter saturates at IMG_W-1 without the macro.
- Frame end: a line ending while row == IMG_H-1 sets m_eof on that beat; row=0; state -> IDLE. Extra beats before the next SOF are dropped.
- s_sof accepted in ACTIVE: treated as restart. Counters reset to 0, pat_q reloaded, the beat is emitted with m_sof=1. The previous frame gets no m_eof.
- m_sof copies s_sof of an emitted beat. m_eol is 1 when the line ends on that beat.
- Widths: no arithmetic on data. The sample is a pure mux. col is clog2(IMG_W) bits, row is clog2(IMG_H) bits.

## Timing
- Latency: 1 cycle. A beat accepted at edge N appears on m_* after edge N with m_valid=1.
- Output register: loads on input accept. It holds m_data and flags stable while m_valid && !m_ready.
- m_valid clears on an m_ready cycle with no new accept.
- Throughput: 1 beat/cycle when m_ready stays high, because simultaneous drain and load is allowed.
- Reset values: m_valid=0, m_data=0, m_sof=0, m_eol=0, m_eof=0, err_len=0, s_ready=1 (IDLE), col=0, row=0, pat_q=0.
- rst mid-frame: the output beat in flight is discarded (m_valid=0 next cycle), and the next frame needs a fresh SOF.
- s_* inputs are don't-care when s_valid=0. m_data is don't-care when m_valid=0 but holds its last value.

## Configuration
- MOSAIC_LEN_CHECK_EN defined:
  - err_len pulses for one cycle on the output cycle of the offending beat when s_eol arrives with col != IMG_W-1.
  - err_len also pulses when col == IMG_W-1 without s_eol. The line is then force-ended: m_eol=1, row advances, col=0.
  - An SOF accepted in ACTIVE also pulses err_len.
- MOSAIC_LEN_CHECK_EN undefined: err_len is tied 0 and lines end only on s_eol.

## Test plan
- IMG_W=4, IMG_H=2, cfg_pattern=0, pixel k = (R=0x100+k, G=0x200+k, B=0x300+k), m_ready=1:
  - m_data must be 0x100,0x201,0x102,0x203,0x204,0x305,0x206,0x307.
  - m_sof must be set on beat 0, m_eol on beats 3 and 7, m_eof on beat 7.
  - Latency must be 1 cycle.
- Same frame with cfg_pattern=3: m_data must be 0x300,0x201,0x302,0x203,0x204,0x105,0x206,0x107.
- Back-pressure:
  - Hold m_ready=0 for 5 cycles mid-line: m_data is stable, s_ready=0, and no beat is lost or duplicated.
  - Toggle m_ready on alternate cycles: the output sequence is identical to the first test.
- Drop and restart:
  - 3 beats without SOF in IDLE produce no output.
  - An SOF in the middle of row 1 restarts the frame: output is R at col 0, and the old frame gets no m_eof.
- MOSAIC_LEN_CHECK_EN on:
  - s_eol at col 2 gives err_len=1 for exactly 1 cycle.
  - 5 beats without s_eol force m_eol on beat 3 and pulse err_len. Beat 4 is mapped as row 1, col 0 (G under RGGB).
- rst asserted while m_valid=1 and m_ready=0: the next cycle has m_valid=0 and s_ready=1, and a subsequent SOF frame matches the first test.
